// File: rtl/spi_reg_arb_pkg.sv
// Shared types and constants for the SPI configuration-register arbiter.
package spi_reg_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 2;
  localparam int unsigned DEF_NUM_CFG   = 16;
  localparam int unsigned DEF_REG_WIDTH = 8;
  localparam int unsigned DEF_ADDR_W    = 4;

  // Write-protect lock location (used only when SPI_REG_ARB_WPROT_EN is defined)
  localparam int unsigned LOCK_REG = 0;
  localparam int unsigned LOCK_BIT = DEF_REG_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: lowest index strictly above last_gnt, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_idx
);

  int cand;

  // Scan offsets from farthest to nearest so the nearest requester overrides
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last_gnt;
    cand      = 0;
    for (int off = int'(NUM_REQ); off >= 1; off--) begin
      cand = (int'(last_gnt) + off) % int'(NUM_REQ);
      if (req[IDW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Round-robin shared-access controller for the SPI configuration register bank.
// Optional feature macro: SPI_REG_ARB_WPROT_EN (register 0 MSB locks writes from
// requesters other than 0).
module spi_reg_arbiter
  import spi_reg_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter  int unsigned NUM_CFG   = DEF_NUM_CFG,
  parameter  int unsigned REG_WIDTH = DEF_REG_WIDTH,
  parameter  int unsigned ADDR_W    = DEF_ADDR_W,
  localparam int unsigned IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]  wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic [REG_WIDTH-1:0]          rdata,
  output logic [IDW-1:0]                gnt_id,
  output logic                          busy,
  output logic [NUM_CFG*REG_WIDTH-1:0]  config_regs
);

  localparam int unsigned IW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam logic [ADDR_W:0] CFG_LIMIT = (ADDR_W + 1)'(NUM_CFG);

  arb_state_e state, state_nxt;

  logic [IDW-1:0]       last_gnt;
  logic                 win_valid;
  logic [IDW-1:0]       win_idx;
  logic                 grant_c;

  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [REG_WIDTH-1:0] wdata_q;

  logic [REG_WIDTH-1:0] regs [NUM_CFG];

  logic                 in_range_c;
  logic                 locked_c;
  logic                 wr_en_c;
  logic [IW-1:0]        reg_idx_c;
  logic [REG_WIDTH-1:0] cur_val_c;
  logic [NUM_REQ-1:0]   gnt_onehot_c;
  logic [NUM_REQ-1:0]   ack_c;
  logic [NUM_REQ-1:0]   err_c;
  logic [REG_WIDTH-1:0] rdata_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req),
    .last_gnt  (last_gnt),
    .gnt_valid (win_valid),
    .gnt_idx   (win_idx)
  );

  assign grant_c = (state == IDLE) && win_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access decode and completion values computed during ACCESS
  always_comb begin
    in_range_c   = ({1'b0, addr_q} < CFG_LIMIT);
    reg_idx_c    = in_range_c ? IW'(addr_q) : '0;
    cur_val_c    = regs[reg_idx_c];
    locked_c     = 1'b0;
`ifdef SPI_REG_ARB_WPROT_EN
    locked_c     = regs[IW'(LOCK_REG)][REG_WIDTH-1] && (gnt_id != '0);
`endif
    gnt_onehot_c = NUM_REQ'(1) << gnt_id;
    wr_en_c      = (state == ACCESS) && we_q && in_range_c && !locked_c;
    ack_c        = '0;
    err_c        = '0;
    rdata_c      = '0;
    if (state == ACCESS) begin
      ack_c = gnt_onehot_c;
      if (!in_range_c || (we_q && locked_c)) err_c = gnt_onehot_c;
      if (in_range_c) rdata_c = wr_en_c ? wdata_q : cur_val_c;
    end
  end

  // Latch the winner's request and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= IDW'(NUM_REQ - 1);
      gnt_id   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (grant_c) begin
      last_gnt <= win_idx;
      gnt_id   <= win_idx;
      we_q     <= we[win_idx];
      addr_q   <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
      wdata_q  <= wdata[int'(win_idx)*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Register bank; a write commits at the end of the ACCESS cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_CFG); k++) regs[k] <= '0;
    end else if (wr_en_c) begin
      regs[reg_idx_c] <= wdata_q;
    end
  end

  // Registered handshake outputs; ack/err/rdata are live only in ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= '0;
      err   <= '0;
      rdata <= '0;
      busy  <= 1'b0;
    end else begin
      ack   <= ack_c;
      err   <= err_c;
      rdata <= rdata_c;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Flatten the bank onto the output bus
  for (genvar k = 0; k < int'(NUM_CFG); k++) begin : g_flat
    assign config_regs[k*REG_WIDTH +: REG_WIDTH] = regs[k];
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter against a transaction-level model.
module tb_spi_reg_arbiter;

  localparam int NREQ = 2;
  localparam int NCFG = 12;
  localparam int RW   = 8;
  localparam int AW   = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*RW-1:0]   wdata;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic [RW-1:0]        rdata;
  logic [0:0]           gnt_id;
  logic                 busy;
  logic [NCFG*RW-1:0]   config_regs;

  logic                 s_we    [NREQ];
  logic [AW-1:0]        s_addr  [NREQ];
  logic [RW-1:0]        s_wdata [NREQ];

  logic [RW-1:0]        mregs [NCFG];
  int                   mlast;
  int                   errors;
  int                   checks;

  spi_reg_arbiter #(
    .NUM_REQ(NREQ), .NUM_CFG(NCFG), .REG_WIDTH(RW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
    .config_regs(config_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      we[i]              = s_we[i];
      addr[i*AW +: AW]   = s_addr[i];
      wdata[i*RW +: RW]  = s_wdata[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next winner: lowest index strictly above the previous grant, wrapping
  function automatic int pick(input logic [NREQ-1:0] r);
    for (int off = 1; off <= NREQ; off++) begin
      int c;
      c = (mlast + off) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NCFG*RW-1:0] model_flat();
    logic [NCFG*RW-1:0] v;
    for (int k = 0; k < NCFG; k++) v[k*RW +: RW] = mregs[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCFG; k++) mregs[k] = '0;
    mlast = NREQ - 1;
  endtask

  // Apply one access to the model and return expected err/rdata
  task automatic model_access(input int w, output logic e, output logic [RW-1:0] rd);
    int  a;
    bit  blocked;
    a       = int'(s_addr[w]);
    blocked = 1'b0;
`ifdef SPI_REG_ARB_WPROT_EN
    blocked = mregs[0][RW-1] && (w != 0);
`endif
    if (a >= NCFG) begin
      e = 1'b1; rd = '0;
    end else if (s_we[w] && blocked) begin
      e = 1'b1; rd = mregs[a];
    end else if (s_we[w]) begin
      mregs[a] = s_wdata[w]; e = 1'b0; rd = s_wdata[w];
    end else begin
      e = 1'b0; rd = mregs[a];
    end
    mlast = w;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [RW-1:0] d);
    s_we[i] = w; s_addr[i] = a; s_wdata[i] = d; req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One full access starting in an IDLE cycle with at least one request pending
  task automatic round(input bit keep, input bit drop_early);
    int            w;
    logic          e;
    logic [RW-1:0] rd;
    w = pick(req);
    if (w < 0) begin
      checks++; errors++;
      $error("FAIL round_no_req: observed=%0h expected=nonzero", req);
      return;
    end
    @(posedge clk); #1;
    chk("access_busy", 128'(busy), 128'(1));
    chk("access_ack", 128'(ack), 128'(0));
    chk("access_gnt_id", 128'(gnt_id), 128'(w));
    model_access(w, e, rd);
    if (drop_early) req[w] = 1'b0;
    @(posedge clk); #1;
    chk("ack", 128'(ack), 128'(1 << w));
    chk("err", 128'(err), e ? 128'(1 << w) : 128'(0));
    chk("rdata", 128'(rdata), 128'(rd));
    chk("config_regs", 128'(config_regs), 128'(model_flat()));
    chk("ack_busy", 128'(busy), 128'(1));
    if (!keep) req[w] = 1'b0;
    @(posedge clk); #1;
    chk("idle_ack", 128'(ack), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    req    = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0;
    end

    // Reset state
    do_reset();
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    chk("rst_gnt_id", 128'(gnt_id), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_config", 128'(config_regs), 128'(0));
    @(posedge clk); #1;
    chk("idle_noreq_busy", 128'(busy), 128'(0));

    // Single write then read
    set_req(0, 1'b1, 4'd3, 8'hA5);
    round(1'b0, 1'b0);
    chk("wr_reg3", 128'(config_regs[31:24]), 128'(8'hA5));
    set_req(0, 1'b0, 4'd3, 8'h00);
    round(1'b0, 1'b0);

    // Contention after reset: r0 first, then r1
    do_reset();
    set_req(0, 1'b1, 4'd1, 8'h5A);
    set_req(1, 1'b1, 4'd1, 8'hC3);
    round(1'b0, 1'b0);
    chk("contend_first", 128'(gnt_id), 128'(0));
    round(1'b0, 1'b0);
    chk("contend_second", 128'(gnt_id), 128'(1));

    // Both held: grants alternate 0,1,0,1
    set_req(0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b1, 4'd7, 8'h3E);
    for (int n = 0; n < 4; n++) begin
      round(1'b1, 1'b0);
      chk("alternate", 128'(gnt_id), 128'(n % 2));
    end
    req = '0;
    @(posedge clk); #1;

    // Out-of-range write from r1
    set_req(1, 1'b1, 4'd14, 8'hFF);
    round(1'b0, 1'b0);

    // Request dropped during ACCESS still completes
    set_req(0, 1'b1, 4'd2, 8'h11);
    round(1'b0, 1'b1);
    chk("drop_reg2", 128'(config_regs[23:16]), 128'(8'h11));

    // Randomized mix of reads/writes/out-of-range from both requesters
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 8'($urandom));
      end
      if (req == '0)
        set_req(int'($urandom_range(NREQ - 1, 0)), 1'($urandom_range(1, 0)),
                4'($urandom_range(15, 0)), 8'($urandom));
      round(1'b0, 1'b0);
    end
    req = '0;
    @(posedge clk); #1;

    // Reset during ACCESS discards the write and issues no ack
    set_req(0, 1'b1, 4'd9, 8'h7E);
    round(1'b0, 1'b0);
    set_req(0, 1'b1, 4'd5, 8'h3C);
    @(posedge clk); #1;
    chk("midrst_in_access", 128'(busy), 128'(1));
    rst    = 1'b1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    chk("midrst_ack", 128'(ack), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_config", 128'(config_regs), 128'(0));
    @(posedge clk); #1;
    chk("midrst_no_late_ack", 128'(ack), 128'(0));
    chk("midrst_idle", 128'(busy), 128'(0));

`ifdef SPI_REG_ARB_WPROT_EN
    // Lock set by r0 blocks r1 writes; clearing it lets r1 through
    set_req(0, 1'b1, 4'd0, 8'h80);
    round(1'b0, 1'b0);
    set_req(1, 1'b1, 4'd4, 8'h22);
    round(1'b0, 1'b0);
    chk("wprot_err", 128'(config_regs[39:32]), 128'(8'h00));
    set_req(1, 1'b0, 4'd0, 8'h00);
    round(1'b0, 1'b0);
    set_req(0, 1'b1, 4'd0, 8'h00);
    round(1'b0, 1'b0);
    set_req(1, 1'b1, 4'd4, 8'h22);
    round(1'b0, 1'b0);
    chk("wprot_retry", 128'(config_regs[39:32]), 128'(8'h22));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
